// File: rtl/ravenoc_pkg.sv
// Shared types for the NoC receive path: flit type encoding, per-VC
// reassembly state, framing error codes and the status pulse bundle.
package ravenoc_pkg;

   typedef enum logic [1:0] {
      HEAD_FLIT = 2'b00,
      BODY_FLIT = 2'b01,
      TAIL_FLIT = 2'b10,
      BAD_FLIT  = 2'b11
   } flit_type_t;

   typedef enum logic [1:0] {
      ERR_ORPHAN  = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_NESTED  = 2'd2,
      ERR_BADTYPE = 2'd3
   } rx_err_code_t;

   typedef enum logic [1:0] {
      VC_IDLE    = 2'd0,
      VC_PAYLOAD = 2'd1,
      VC_DROP    = 2'd2
   } rx_vc_state_t;

   typedef struct packed {
      logic         done;
      logic         err;
      rx_err_code_t code;
   } s_rx_status_t;

endpackage

// File: rtl/rx_vc_tracker.sv
// Framing tracker for a single virtual channel: decodes what the incoming
// flit means for this VC and advances state/rem/cnt when the flit is ours.
module rx_vc_tracker
   import ravenoc_pkg::*;
#(
   parameter int PktWidth = 8
) (
   input  logic                clk_axi,
   input  logic                arst_axi,
   input  logic                en,
   input  flit_type_t          ftype,
   input  logic [PktWidth-1:0] len,
   output logic                fwd,
   output logic                sop,
   output logic                eop,
   output s_rx_status_t        status,
   output logic [PktWidth-1:0] done_len
);

   localparam logic [PktWidth-1:0] CntMax = '1;
   localparam logic [PktWidth-1:0] One    = PktWidth'(1);

   rx_vc_state_t        state, state_nxt;
   logic [PktWidth-1:0] rem, rem_nxt;
   logic [PktWidth-1:0] cnt, cnt_nxt;
   logic [PktWidth-1:0] cnt_inc;

   // Reported length counts flits after the head, saturating at the field max.
   assign cnt_inc = (cnt == CntMax) ? cnt : cnt + One;

   always_comb begin
      fwd         = 1'b0;
      sop         = 1'b0;
      eop         = 1'b0;
      status.done = 1'b0;
      status.err  = 1'b0;
      status.code = ERR_ORPHAN;
      done_len    = '0;
      state_nxt   = state;
      rem_nxt     = rem;
      cnt_nxt     = cnt;
      case (ftype)
         HEAD_FLIT: begin
            fwd = 1'b1;
            sop = 1'b1;
            if (state != VC_IDLE) begin
               status.err  = 1'b1;
               status.code = ERR_NESTED;
            end
            rem_nxt = len;
            cnt_nxt = '0;
            if (len == '0) begin
               eop         = 1'b1;
               status.done = 1'b1;
               state_nxt   = VC_IDLE;
            end else begin
               state_nxt = VC_PAYLOAD;
            end
         end
         BODY_FLIT: begin
            case (state)
               VC_IDLE: begin
                  status.err  = 1'b1;
                  status.code = ERR_ORPHAN;
               end
               VC_PAYLOAD: begin
                  fwd = 1'b1;
                  if (rem > One) begin
                     rem_nxt = rem - One;
                     cnt_nxt = cnt_inc;
                  end else begin
                     // Too long: close the packet here and swallow the rest.
                     eop         = 1'b1;
                     status.done = 1'b1;
                     status.err  = 1'b1;
                     status.code = ERR_LEN;
                     done_len    = cnt_inc;
                     state_nxt   = VC_DROP;
                  end
               end
               default: ;
            endcase
         end
         TAIL_FLIT: begin
            case (state)
               VC_IDLE: begin
                  status.err  = 1'b1;
                  status.code = ERR_ORPHAN;
               end
               VC_PAYLOAD: begin
                  fwd         = 1'b1;
                  eop         = 1'b1;
                  status.done = 1'b1;
                  done_len    = cnt_inc;
                  state_nxt   = VC_IDLE;
                  if (rem > One) begin
                     status.err  = 1'b1;
                     status.code = ERR_LEN;
                  end
               end
               default: state_nxt = VC_IDLE;
            endcase
         end
         default: begin
            status.err  = 1'b1;
            status.code = ERR_BADTYPE;
         end
      endcase
   end

   always_ff @(posedge clk_axi) begin
      if (arst_axi) begin
         state <= VC_IDLE;
         rem   <= '0;
         cnt   <= '0;
      end else if (en) begin
         state <= state_nxt;
         rem   <= rem_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: rtl/flit_rx_reasm.sv
// Receive-side flit reassembler: strips flit types, tracks framing per VC,
// and drives a registered payload stage plus single-cycle status pulses.
module flit_rx_reasm
   import ravenoc_pkg::*;
#(
   parameter int NumVcs        = 3,
   parameter int FlitWidth     = 34,
   parameter int FlitDataWidth = 32,
   parameter int PktWidth      = 8,
   parameter int LenLsb        = 0,
   parameter int VcW           = $clog2(NumVcs)
) (
   input  logic                     clk_axi,
   input  logic                     arst_axi,
   input  logic                     flit_valid_i,
   output logic                     flit_ready_o,
   input  logic [FlitWidth-1:0]     flit_i,
   input  logic [VcW-1:0]           flit_vc_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [FlitDataWidth-1:0] out_data_o,
   output logic [VcW-1:0]           out_vc_o,
   output logic                     out_sop_o,
   output logic                     out_eop_o,
   output logic                     pkt_done_o,
   output logic [VcW-1:0]           pkt_done_vc_o,
   output logic [PktWidth-1:0]      pkt_len_o,
   output logic                     err_o,
   output logic [1:0]               err_code_o,
   output logic [VcW-1:0]           err_vc_o
);

   flit_type_t                 ftype;
   logic [FlitDataWidth-1:0]   fdata;
   logic                       accept;

   logic                       fwd_v    [NumVcs];
   logic                       sop_v    [NumVcs];
   logic                       eop_v    [NumVcs];
   s_rx_status_t               status_v [NumVcs];
   logic [PktWidth-1:0]        len_v    [NumVcs];

   logic                       sel_fwd, sel_sop, sel_eop;
   s_rx_status_t               sel_status;
   logic [PktWidth-1:0]        sel_len;

   assign ftype        = flit_type_t'(flit_i[FlitWidth-1 -: 2]);
   assign fdata        = flit_i[FlitDataWidth-1:0];
   assign flit_ready_o = ~out_valid_o | out_ready_i;
   assign accept       = flit_valid_i & flit_ready_o;

   for (genvar g = 0; g < NumVcs; g++) begin : g_vc
      rx_vc_tracker #(
         .PktWidth(PktWidth)
      ) u_tracker (
         .clk_axi  (clk_axi),
         .arst_axi (arst_axi),
         .en       (accept && (flit_vc_i == VcW'(g))),
         .ftype    (ftype),
         .len      (fdata[LenLsb +: PktWidth]),
         .fwd      (fwd_v[g]),
         .sop      (sop_v[g]),
         .eop      (eop_v[g]),
         .status   (status_v[g]),
         .done_len (len_v[g])
      );
   end

   // A VC index outside the tracked range selects nothing, so the flit is
   // consumed without effect.
   always_comb begin
      sel_fwd    = 1'b0;
      sel_sop    = 1'b0;
      sel_eop    = 1'b0;
      sel_status = '0;
      sel_len    = '0;
      for (int i = 0; i < NumVcs; i++) begin
         if (flit_vc_i == VcW'(i)) begin
            sel_fwd    = fwd_v[i];
            sel_sop    = sop_v[i];
            sel_eop    = eop_v[i];
            sel_status = status_v[i];
            sel_len    = len_v[i];
         end
      end
   end

   always_ff @(posedge clk_axi) begin
      if (arst_axi) begin
         out_valid_o   <= 1'b0;
         out_data_o    <= '0;
         out_vc_o      <= '0;
         out_sop_o     <= 1'b0;
         out_eop_o     <= 1'b0;
         pkt_done_o    <= 1'b0;
         pkt_done_vc_o <= '0;
         pkt_len_o     <= '0;
         err_o         <= 1'b0;
         err_code_o    <= '0;
         err_vc_o      <= '0;
      end else begin
         if (~out_valid_o | out_ready_i) begin
            out_valid_o <= accept & sel_fwd;
         end
         if (accept & sel_fwd) begin
            out_data_o <= fdata;
            out_vc_o   <= flit_vc_i;
            out_sop_o  <= sel_sop;
            out_eop_o  <= sel_eop;
         end
         // Status pulses bypass the payload stage and never wait on out_ready_i.
         pkt_done_o <= accept & sel_status.done;
         err_o      <= accept & sel_status.err;
         if (accept & sel_status.done) begin
            pkt_done_vc_o <= flit_vc_i;
            pkt_len_o     <= sel_len;
         end
         if (accept & sel_status.err) begin
            err_code_o <= sel_status.code;
            err_vc_o   <= flit_vc_i;
         end
      end
   end

endmodule

// File: tb/tb_flit_rx_reasm.sv
// Directed bench for flit_rx_reasm: hand-computed expectations checked with
// immediate assertions after each accepted flit.
module tb_flit_rx_reasm;

   localparam int NumVcs = 3;
   localparam int VcW    = 2;

   logic        clk_axi = 1'b0;
   logic        arst_axi;
   logic        flit_valid_i;
   logic        flit_ready_o;
   logic [33:0] flit_i;
   logic [1:0]  flit_vc_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_data_o;
   logic [1:0]  out_vc_o;
   logic        out_sop_o;
   logic        out_eop_o;
   logic        pkt_done_o;
   logic [1:0]  pkt_done_vc_o;
   logic [7:0]  pkt_len_o;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic [1:0]  err_vc_o;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, BAD = 2'b11;

   always #5 clk_axi = ~clk_axi;

   flit_rx_reasm #(
      .NumVcs(NumVcs)
   ) dut (
      .clk_axi       (clk_axi),
      .arst_axi      (arst_axi),
      .flit_valid_i  (flit_valid_i),
      .flit_ready_o  (flit_ready_o),
      .flit_i        (flit_i),
      .flit_vc_i     (flit_vc_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_data_o    (out_data_o),
      .out_vc_o      (out_vc_o),
      .out_sop_o     (out_sop_o),
      .out_eop_o     (out_eop_o),
      .pkt_done_o    (pkt_done_o),
      .pkt_done_vc_o (pkt_done_vc_o),
      .pkt_len_o     (pkt_len_o),
      .err_o         (err_o),
      .err_code_o    (err_code_o),
      .err_vc_o      (err_vc_o)
   );

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_axi);
      #1;
   endtask

   // Presents one flit, waits (bounded) for acceptance, then returns 1 time
   // unit after the accepting edge so the registered results are visible.
   task automatic apply_stimulus(input logic [1:0] vc, input logic [1:0] ftype, input logic [31:0] data);
      int n;
      flit_vc_i    = vc;
      flit_i       = {ftype, data};
      flit_valid_i = 1'b1;
      n = 0;
      while (!flit_ready_o && n < 50) begin
         tick();
         n++;
      end
      if (!flit_ready_o) check_output("accept_timeout", 64'(flit_ready_o), 64'd1);
      tick();
      flit_valid_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      arst_axi     = 1'b1;
      flit_valid_i = 1'b0;
      flit_i       = '0;
      flit_vc_i    = '0;
      out_ready_i  = 1'b1;
      tick();
      tick();
      arst_axi = 1'b0;
      check_output("rst_out_valid", 64'(out_valid_o), 64'd0);
      check_output("rst_out_data", 64'(out_data_o), 64'd0);
      check_output("rst_pkt_done", 64'(pkt_done_o), 64'd0);
      check_output("rst_err", 64'(err_o), 64'd0);
      check_output("rst_flit_ready", 64'(flit_ready_o), 64'd1);

      // Basic three-flit packet on VC0
      apply_stimulus(2'd0, HEAD, 32'hA000_0002);
      check_output("p1_head_valid", 64'(out_valid_o), 64'd1);
      check_output("p1_head_data", 64'(out_data_o), 64'hA000_0002);
      check_output("p1_head_sop", 64'(out_sop_o), 64'd1);
      check_output("p1_head_eop", 64'(out_eop_o), 64'd0);
      check_output("p1_head_done", 64'(pkt_done_o), 64'd0);
      apply_stimulus(2'd0, BODY, 32'h0000_0011);
      check_output("p1_body_data", 64'(out_data_o), 64'h11);
      check_output("p1_body_sop", 64'(out_sop_o), 64'd0);
      check_output("p1_body_eop", 64'(out_eop_o), 64'd0);
      apply_stimulus(2'd0, TAIL, 32'h0000_0022);
      check_output("p1_tail_data", 64'(out_data_o), 64'h22);
      check_output("p1_tail_eop", 64'(out_eop_o), 64'd1);
      check_output("p1_done", 64'(pkt_done_o), 64'd1);
      check_output("p1_done_vc", 64'(pkt_done_vc_o), 64'd0);
      check_output("p1_len", 64'(pkt_len_o), 64'd2);
      check_output("p1_err", 64'(err_o), 64'd0);
      tick();
      check_output("p1_idle_valid", 64'(out_valid_o), 64'd0);
      check_output("p1_done_pulse", 64'(pkt_done_o), 64'd0);

      // Zero-length packet on VC1
      apply_stimulus(2'd1, HEAD, 32'h0000_0000);
      check_output("p2_sop", 64'(out_sop_o), 64'd1);
      check_output("p2_eop", 64'(out_eop_o), 64'd1);
      check_output("p2_vc", 64'(out_vc_o), 64'd1);
      check_output("p2_done", 64'(pkt_done_o), 64'd1);
      check_output("p2_done_vc", 64'(pkt_done_vc_o), 64'd1);
      check_output("p2_len", 64'(pkt_len_o), 64'd0);

      // Interleaved VC0/VC2 packets
      apply_stimulus(2'd0, HEAD, 32'h0000_0001);
      check_output("p3_h0_vc", 64'(out_vc_o), 64'd0);
      apply_stimulus(2'd2, HEAD, 32'h0000_0001);
      check_output("p3_h2_vc", 64'(out_vc_o), 64'd2);
      check_output("p3_h2_done", 64'(pkt_done_o), 64'd0);
      apply_stimulus(2'd2, TAIL, 32'h0000_0033);
      check_output("p3_t2_vc", 64'(out_vc_o), 64'd2);
      check_output("p3_t2_done_vc", 64'(pkt_done_vc_o), 64'd2);
      check_output("p3_t2_len", 64'(pkt_len_o), 64'd1);
      apply_stimulus(2'd0, TAIL, 32'h0000_0044);
      check_output("p3_t0_data", 64'(out_data_o), 64'h44);
      check_output("p3_t0_done", 64'(pkt_done_o), 64'd1);
      check_output("p3_t0_done_vc", 64'(pkt_done_vc_o), 64'd0);
      check_output("p3_t0_len", 64'(pkt_len_o), 64'd1);
      check_output("p3_t0_err", 64'(err_o), 64'd0);

      // Orphan body, then a short packet on VC1
      apply_stimulus(2'd1, BODY, 32'h0000_0055);
      check_output("p4_orph_valid", 64'(out_valid_o), 64'd0);
      check_output("p4_orph_err", 64'(err_o), 64'd1);
      check_output("p4_orph_code", 64'(err_code_o), 64'd0);
      check_output("p4_orph_vc", 64'(err_vc_o), 64'd1);
      apply_stimulus(2'd1, HEAD, 32'h0000_0003);
      check_output("p4_head_err", 64'(err_o), 64'd0);
      apply_stimulus(2'd1, BODY, 32'h0000_0066);
      apply_stimulus(2'd1, TAIL, 32'h0000_0077);
      check_output("p4_tail_eop", 64'(out_eop_o), 64'd1);
      check_output("p4_done", 64'(pkt_done_o), 64'd1);
      check_output("p4_len", 64'(pkt_len_o), 64'd2);
      check_output("p4_err", 64'(err_o), 64'd1);
      check_output("p4_code", 64'(err_code_o), 64'd1);

      // Long packet on VC0: trailing flits dropped
      apply_stimulus(2'd0, HEAD, 32'h0000_0001);
      apply_stimulus(2'd0, BODY, 32'h0000_0088);
      check_output("p5_b1_valid", 64'(out_valid_o), 64'd1);
      check_output("p5_b1_eop", 64'(out_eop_o), 64'd1);
      check_output("p5_b1_done", 64'(pkt_done_o), 64'd1);
      check_output("p5_b1_len", 64'(pkt_len_o), 64'd1);
      check_output("p5_b1_code", 64'(err_code_o), 64'd1);
      check_output("p5_b1_err_vc", 64'(err_vc_o), 64'd0);
      apply_stimulus(2'd0, BODY, 32'h0000_0099);
      check_output("p5_b2_valid", 64'(out_valid_o), 64'd0);
      check_output("p5_b2_err", 64'(err_o), 64'd0);
      apply_stimulus(2'd0, TAIL, 32'h0000_00AA);
      check_output("p5_t_valid", 64'(out_valid_o), 64'd0);
      check_output("p5_t_err", 64'(err_o), 64'd0);
      apply_stimulus(2'd0, BODY, 32'h0000_00BB);
      check_output("p5_idle_err", 64'(err_o), 64'd1);
      check_output("p5_idle_code", 64'(err_code_o), 64'd0);

      // Nested head on VC2 and an invalid flit type on VC1
      apply_stimulus(2'd2, HEAD, 32'h0000_0002);
      apply_stimulus(2'd2, HEAD, 32'h0000_0000);
      check_output("nest_err", 64'(err_o), 64'd1);
      check_output("nest_code", 64'(err_code_o), 64'd2);
      check_output("nest_done", 64'(pkt_done_o), 64'd1);
      check_output("nest_sop_eop", 64'({out_sop_o, out_eop_o}), 64'd3);
      apply_stimulus(2'd1, BAD, 32'h0000_0001);
      check_output("bad_valid", 64'(out_valid_o), 64'd0);
      check_output("bad_code", 64'(err_code_o), 64'd3);
      check_output("bad_vc", 64'(err_vc_o), 64'd1);

      // Backpressure mid-packet on VC0
      apply_stimulus(2'd0, HEAD, 32'hB000_0002);
      out_ready_i  = 1'b0;
      #1;
      check_output("bp_ready_low", 64'(flit_ready_o), 64'd0);
      flit_vc_i    = 2'd0;
      flit_i       = {BODY, 32'h0000_00CC};
      flit_valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_output("bp_hold_data", 64'(out_data_o), 64'hB000_0002);
         check_output("bp_hold_valid", 64'(out_valid_o), 64'd1);
         check_output("bp_hold_ready", 64'(flit_ready_o), 64'd0);
      end
      out_ready_i = 1'b1;
      tick();
      flit_valid_i = 1'b0;
      check_output("bp_release_data", 64'(out_data_o), 64'hCC);
      check_output("bp_release_sop", 64'(out_sop_o), 64'd0);

      // Reset with VC0 still mid-packet
      arst_axi = 1'b1;
      tick();
      arst_axi = 1'b0;
      check_output("rst2_valid", 64'(out_valid_o), 64'd0);
      check_output("rst2_data", 64'(out_data_o), 64'd0);
      check_output("rst2_done", 64'(pkt_done_o), 64'd0);
      apply_stimulus(2'd0, BODY, 32'h0000_00DD);
      check_output("rst2_orph_err", 64'(err_o), 64'd1);
      check_output("rst2_orph_code", 64'(err_code_o), 64'd0);
      check_output("rst2_orph_valid", 64'(out_valid_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
